alu_mul_sequencer: RTL and testbench

- Multi-cycle sequencer that computes the low 32 bits of a 32x32 product (RISC-V MUL semantics) by driving the shared pipeline ALU with repeated add operations (shift-add algorithm).
- Sits beside the EX stage. The pipeline stalls on `busy`; an external mux grants this block the ALU inputs while `alu_req` is high.
- Owns all control state: operand registers, step counter and FSM.

---
 rtl/alu_mul_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier that borrows the shared pipeline ALU for its adds.
// It produces the low XLEN bits of op_a_i * op_b_i, which are the same for
// signed and unsigned operands.
//
// state | meaning
// IDLE  | waiting for start_i; no ALU request
// STEP  | one multiplier bit per cycle; ALU computes acc + mcand
// DONE  | one-cycle done_o pulse; start_i here chains straight into a new op
module alu_mul_sequencer #(
  parameter int          XLEN       = 32,
  parameter bit          EARLY_EXIT = 1'b1,
  parameter logic [2:0]  OP_ADD     = 3'b000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            alu_req_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [2:0]      alu_op_o,
  input  logic [XLEN-1:0] alu_result_i
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] acc_step;
  logic            last_step;

  // Accumulator after this cycle's conditional add.
  assign acc_step  = mplier_q[0] ? alu_result_i : acc_q;
  // Final step: all bits consumed, or nothing left to add in the upper bits.
  assign last_step = (count_q == CW'(XLEN - 1)) ||
                     (EARLY_EXIT && (mplier_q[XLEN-1:1] == '0));

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath update; flush overrides everything but keeps result.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    result_d = result_q;

    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            acc_d    = '0;
            mcand_d  = op_a_i;
            mplier_d = op_b_i;
            count_d  = '0;
            if (EARLY_EXIT && (op_b_i == '0)) begin
              state_d  = S_DONE;
              result_d = '0;
            end else begin
              state_d = S_STEP;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_STEP: begin
          acc_d    = acc_step;
          mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[XLEN-1:1]};
          count_d  = count_q + 1'b1;
          if (last_step) begin
            state_d  = S_DONE;
            result_d = acc_step;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore outputs; ALU operands are forced to zero whenever the ALU is not ours.
  always_comb begin
    busy_o    = 1'b0;
    done_o    = 1'b0;
    alu_req_o = 1'b0;
    alu_a_o   = '0;
    alu_b_o   = '0;
    alu_op_o  = OP_ADD;
    result_o  = result_q;
    case (state_q)
      S_STEP: begin
        busy_o    = 1'b1;
        alu_req_o = 1'b1;
        alu_a_o   = acc_q;
        alu_b_o   = mcand_q;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench: one instance with early exit, one without, each paired with
// a plain adder standing in for the pipeline ALU.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, start0, flush;
  logic [31:0] op_a, op_b;

  logic        busy1, done1, req1, busy0, done0, req0;
  logic [31:0] res1, a1, b1, alu_r1, res0, a0, b0, alu_r0;
  logic [2:0]  aop1, aop0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign alu_r1 = a1 + b1;
  assign alu_r0 = a0 + b0;

  alu_mul_sequencer #(.XLEN(32), .EARLY_EXIT(1'b1), .OP_ADD(3'b000)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .op_a_i(op_a), .op_b_i(op_b), .busy_o(busy1), .done_o(done1),
    .result_o(res1), .alu_req_o(req1), .alu_a_o(a1), .alu_b_o(b1),
    .alu_op_o(aop1), .alu_result_i(alu_r1)
  );

  alu_mul_sequencer #(.XLEN(32), .EARLY_EXIT(1'b0), .OP_ADD(3'b000)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .flush_i(flush),
    .op_a_i(op_a), .op_b_i(op_b), .busy_o(busy0), .done_o(done0),
    .result_o(res0), .alu_req_o(req0), .alu_a_o(a0), .alu_b_o(b0),
    .alu_op_o(aop0), .alu_result_i(alu_r0)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_k;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input bit sel);
    return sel ? busy0 : busy1;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? done0 : done1;
  endfunction

  function automatic logic [31:0] get_res(input bit sel);
    return sel ? res0 : res1;
  endfunction

  // Start one op on the selected instance and check busy length, result, single done.
  task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_k, input string name);
    int nb = 0;
    int guard = 0;
    @(negedge clk);
    op_a = a; op_b = b;
    if (sel) start0 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start0 = 1'b0;
    while (!get_done(sel) && guard < 40) begin
      if (get_busy(sel)) nb++;
      @(negedge clk);
      guard++;
    end
    chk({name, " done_seen"}, 32'(get_done(sel)), 32'd1);
    chk({name, " busy_cycles"}, 32'(nb), 32'(exp_k));
    chk({name, " result"}, get_res(sel), exp_res);
    @(negedge clk);
    chk({name, " done_once"}, 32'(get_done(sel)), 32'd0);
  endtask

  vec_t vecs[10];
  int   nb, guard, ndone;
  logic [31:0] exp_a[3];
  logic [31:0] exp_b[3];

  initial begin
    vecs[0] = '{32'd3,        32'd5,        32'd15,         3};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  32};
    vecs[2] = '{32'h12345678, 32'h0,        32'h0,          0};
    vecs[3] = '{32'd7,        32'h80000000, 32'h80000000,  32};
    vecs[4] = '{32'h00010000, 32'h00010000, 32'h0,         17};
    vecs[5] = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE,   2};
    vecs[6] = '{32'd123456789,32'd1000,     32'hBE991A08,  10};
    vecs[7] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,   3};
    vecs[8] = '{32'd6,        32'd7,        32'd42,         3};
    vecs[9] = '{32'd2,        32'd3,        32'd6,          2};
    exp_a = '{32'd0, 32'd3, 32'd3};
    exp_b = '{32'd3, 32'd6, 32'd12};

    rst = 1'b1; start = 1'b0; start0 = 1'b0; flush = 1'b0;
    op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy1), 32'd0);
    chk("rst done", 32'(done1), 32'd0);
    chk("rst alu_req", 32'(req1), 32'd0);
    chk("rst result", res1, 32'd0);
    chk("rst alu_a", a1, 32'd0);
    chk("rst alu_b", b1, 32'd0);
    chk("rst alu_op", 32'(aop1), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].exp_res,
                                        vecs[i].exp_k, $sformatf("vec%0d", i));

    // ALU operand trace for 3*5.
    @(negedge clk);
    op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("trace%0d busy", i), 32'(busy1), 32'd1);
      chk($sformatf("trace%0d alu_req", i), 32'(req1), 32'd1);
      chk($sformatf("trace%0d alu_op", i), 32'(aop1), 32'd0);
      chk($sformatf("trace%0d alu_a", i), a1, exp_a[i]);
      chk($sformatf("trace%0d alu_b", i), b1, exp_b[i]);
      @(negedge clk);
    end
    chk("trace done", 32'(done1), 32'd1);
    chk("trace result", res1, 32'd15);
    chk("trace idle alu_a", a1, 32'd0);
    @(negedge clk);

    // Start while busy is ignored.
    op_a = 32'd7; op_b = 32'h80000000; start = 1'b1;
    @(negedge clk);
    nb = 0; guard = 0;
    while (!done1 && guard < 40) begin
      if (busy1) nb++;
      start = (nb == 5);
      op_a = 32'd1; op_b = 32'd1;
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    chk("midstart busy_cycles", 32'(nb), 32'd32);
    chk("midstart done", 32'(done1), 32'd1);
    chk("midstart result", res1, 32'h80000000);
    @(negedge clk);
    chk("midstart done_once", 32'(done1), 32'd0);
    chk("midstart no_restart", 32'(busy1), 32'd0);

    // Back-to-back: second start during the DONE cycle.
    op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; guard = 0;
    while (!done1 && guard < 40) begin @(negedge clk); guard++; end
    chk("b2b first done", 32'(done1), 32'd1);
    chk("b2b first result", res1, 32'd42);
    op_a = 32'd2; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b no_idle busy", 32'(busy1), 32'd1);
    chk("b2b result held", res1, 32'd42);
    nb = 0; guard = 0;
    while (!done1 && guard < 40) begin
      if (busy1) nb++;
      @(negedge clk); guard++;
    end
    chk("b2b second done", 32'(done1), 32'd1);
    chk("b2b second busy_cycles", 32'(nb), 32'd2);
    chk("b2b second result", res1, 32'd6);
    @(negedge clk);

    // Flush at busy cycle 5.
    op_a = 32'h00010000; op_b = 32'h00010000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("flush pre busy", 32'(busy1), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 32'(busy1), 32'd0);
    chk("flush alu_req", 32'(req1), 32'd0);
    chk("flush done", 32'(done1), 32'd0);
    chk("flush result", res1, 32'd6);
    ndone = 0;
    repeat (20) begin @(negedge clk); if (done1 || busy1) ndone++; end
    chk("flush stays idle", 32'(ndone), 32'd0);

    // Flush beats start in the same cycle.
    op_a = 32'd3; op_b = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_vs_start busy", 32'(busy1), 32'd0);
    chk("flush_vs_start done", 32'(done1), 32'd0);
    chk("flush_vs_start result", res1, 32'd6);

    // Reset at busy cycle 5.
    op_a = 32'h00010000; op_b = 32'h00010000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstmid pre busy", 32'(busy1), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid busy", 32'(busy1), 32'd0);
    chk("rstmid done", 32'(done1), 32'd0);
    chk("rstmid alu_req", 32'(req1), 32'd0);
    chk("rstmid result", res1, 32'd0);
    chk("rstmid alu_a", a1, 32'd0);
    chk("rstmid alu_b", b1, 32'd0);
    ndone = 0;
    repeat (20) begin @(negedge clk); if (done1) ndone++; end
    chk("rstmid no_done", 32'(ndone), 32'd0);

    // No early exit: always XLEN steps.
    run_op(1'b1, 32'h12345678, 32'h0, 32'h0, 32, "noee zero");
    run_op(1'b1, 32'd3, 32'd5, 32'd15, 32, "noee 3x5");
    run_op(1'b1, 32'd7, 32'h80000000, 32'h80000000, 32, "noee 7xmsb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
